fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_skid_buf.sv | 72 +++++++
 rtl/fifo_stream_reader.sv | 82 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO stream reader.
// Holds the data-width default, skid-buffer occupancy encoding and counter width.
package fifo_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer; head is always the oldest word.
// Ports: clk, rst, push_i/data_i (capture), pop_i (consume), occ_o, data_o (head).
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output occ_e              occ_o,
    output logic [DATA_W-1:0] data_o
);

    occ_e              occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push_i) begin
                    head_d = data_i;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push_i && pop_i) begin
                    head_d = data_i;
                end else if (push_i) begin
                    tail_d = data_i;
                    occ_d  = OCC_TWO;
                end else if (pop_i) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // Push into a full buffer only happens alongside a pop.
                if (pop_i) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = data_i;
                    end else begin
                        occ_d  = OCC_ONE;
                    end
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ_o  = occ_q;
    assign data_o = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a first-word-fall-through-less FIFO (1-cycle read latency) into a valid/ready stream.
// Ports: clk, rst, fifo_empty/fifo_data/fifo_rd_en (upstream), m_valid/m_data/m_ready (downstream).
// Optional macro FIFO_READER_STATS_EN adds output word_count (popped-word counter).
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [CNT_W-1:0]  word_count
`endif
);

    // Only a depth of 2 is supported; the buffer is hard-wired to two entries.
    localparam logic [2:0] DEPTH3 = 3'(BUF_DEPTH);

    occ_e       occ;
    logic [1:0] occ_n;
    logic       pop;
    logic [2:0] demand;
    logic       inflight_q, inflight_d;

    assign occ_n   = occ;
    assign m_valid = (occ != OCC_EMPTY);
    assign pop     = m_valid & m_ready;

    // Words held plus the word still on its way must fit after this cycle's pop.
    assign demand     = {1'b0, occ_n} + {2'b00, inflight_q};
    assign fifo_rd_en = !rst && !fifo_empty
                        && (demand < DEPTH3 + {2'b00, pop});

    // fifo_rd_en already implies a non-empty FIFO, so it marks an accepted read.
    assign inflight_d = fifo_rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Reset also blocks the capture of a word read just before rst rose.
    fifo_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .push_i (inflight_q),
        .pop_i  (pop),
        .data_i (fifo_data),
        .occ_o  (occ),
        .data_o (m_data)
    );

`ifdef FIFO_READER_STATS_EN
    logic [CNT_W-1:0] count_q, count_d;

    assign count_d = pop ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign word_count = count_q;
`endif

endmodule
